// File: rtl/id_decode_pipe.sv
// id_decode_pipe: ARM-style instruction decode stage with register file and
// ID/EX pipeline register.
// Ports: clk, rst (sync, active-high); in_valid/instr/pc/status in;
//   hazard/flush/freeze stage control; wb_en/wb_dest/wb_value write-back;
//   src1/src2/two_src combinational read info; ex_* registered EX bundle.
// Option: define ID_WB_BYPASS_EN for write-through reads of the write port.
module id_decode_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [3:0]        status,
    input  logic              hazard,
    input  logic              flush,
    input  logic              freeze,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic              two_src,
    output logic              ex_valid,
    output logic [3:0]        ex_exe_cmd,
    output logic              ex_mem_r,
    output logic              ex_mem_w,
    output logic              ex_wb_en,
    output logic              ex_branch,
    output logic              ex_s,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_val_rn,
    output logic [DATA_W-1:0] ex_val_rm,
    output logic [11:0]       ex_shift_op,
    output logic              ex_imm,
    output logic [23:0]       ex_imm24,
    output logic [3:0]        ex_dest
);

    localparam logic [4:0] NREG = 5'(NUM_REGS);

    typedef struct packed {
        logic              valid;
        logic [3:0]        cmd;
        logic              mem_r;
        logic              mem_w;
        logic              wb_en;
        logic              branch;
        logic              s;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic [11:0]       shift_op;
        logic              imm;
        logic [23:0]       imm24;
        logic [3:0]        dest;
    } ex_t;

    ex_t ex_q, ex_d;

    logic [DATA_W-1:0] rf_q [NUM_REGS];

    logic [3:0] cond, opc;
    logic [1:0] mode;
    logic       i_bit, s_bit, is_store;
    logic       n_f, z_f, c_f, v_f;
    logic       cond_ok;
    logic [3:0] d_cmd;
    logic       d_ok, d_mem_r, d_mem_w, d_wb, d_br, d_s;
    logic       take;
    logic [DATA_W-1:0] val_rn, val_rm;

    assign cond  = instr[31:28];
    assign mode  = instr[27:26];
    assign i_bit = instr[25];
    assign opc   = instr[24:21];
    assign s_bit = instr[20];
    assign {n_f, z_f, c_f, v_f} = status;

    assign is_store = (mode == 2'b01) && !s_bit;
    assign src1     = instr[19:16];
    assign src2     = is_store ? instr[15:12] : instr[3:0];
    assign two_src  = ((mode == 2'b00) && !i_bit) || is_store;

    always_comb begin
        case (cond)
            4'h0:    cond_ok = z_f;
            4'h1:    cond_ok = !z_f;
            4'h2:    cond_ok = c_f;
            4'h3:    cond_ok = !c_f;
            4'h4:    cond_ok = n_f;
            4'h5:    cond_ok = !n_f;
            4'h6:    cond_ok = v_f;
            4'h7:    cond_ok = !v_f;
            4'h8:    cond_ok = c_f && !z_f;
            4'h9:    cond_ok = !c_f || z_f;
            4'hA:    cond_ok = (n_f == v_f);
            4'hB:    cond_ok = (n_f != v_f);
            4'hC:    cond_ok = !z_f && (n_f == v_f);
            4'hD:    cond_ok = z_f || (n_f != v_f);
            4'hE:    cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        d_cmd   = 4'b0000;
        d_ok    = 1'b0;
        d_mem_r = 1'b0;
        d_mem_w = 1'b0;
        d_wb    = 1'b0;
        d_br    = 1'b0;
        d_s     = 1'b0;
        unique case (mode)
            2'b00: begin
                d_ok = 1'b1;
                d_wb = 1'b1;
                d_s  = s_bit;
                case (opc)
                    4'b1101: d_cmd = 4'b0001;
                    4'b1111: d_cmd = 4'b1001;
                    4'b0100: d_cmd = 4'b0010;
                    4'b0101: d_cmd = 4'b0011;
                    4'b0010: d_cmd = 4'b0100;
                    4'b0110: d_cmd = 4'b0101;
                    4'b0000: d_cmd = 4'b0110;
                    4'b1100: d_cmd = 4'b0111;
                    4'b0001: d_cmd = 4'b1000;
                    4'b1010: begin
                        d_cmd = 4'b0100;
                        d_wb  = 1'b0;
                    end
                    4'b1000: begin
                        d_cmd = 4'b0110;
                        d_wb  = 1'b0;
                    end
                    default: d_ok = 1'b0;
                endcase
            end
            2'b01: begin
                d_ok    = 1'b1;
                d_cmd   = 4'b0010;
                d_mem_r = s_bit;
                d_mem_w = !s_bit;
                d_wb    = s_bit;
            end
            2'b10: begin
                d_ok = 1'b1;
                d_br = 1'b1;
            end
            default: d_ok = 1'b0;
        endcase
    end

    // Unimplemented indices read as zero; the optional bypass forwards
    // a same-cycle write so the consumer sees it without a stall.
    always_comb begin
        val_rn = '0;
        val_rm = '0;
        if ({1'b0, src1} < NREG) val_rn = rf_q[src1];
        if ({1'b0, src2} < NREG) val_rm = rf_q[src2];
`ifdef ID_WB_BYPASS_EN
        if (wb_en && (wb_dest == src1) && ({1'b0, src1} < NREG))
            val_rn = wb_value;
        if (wb_en && (wb_dest == src2) && ({1'b0, src2} < NREG))
            val_rm = wb_value;
`endif
    end

    assign take = in_valid && !hazard && cond_ok && d_ok && !flush;

    // flush overrides freeze; otherwise freeze holds the whole bundle.
    always_comb begin
        ex_d = ex_q;
        if (flush || !freeze) begin
            ex_d.valid    = take;
            ex_d.cmd      = take ? d_cmd : 4'b0000;
            ex_d.mem_r    = take && d_mem_r;
            ex_d.mem_w    = take && d_mem_w;
            ex_d.wb_en    = take && d_wb;
            ex_d.branch   = take && d_br;
            ex_d.s        = take && d_s;
            ex_d.pc       = pc;
            ex_d.val_rn   = val_rn;
            ex_d.val_rm   = val_rm;
            ex_d.shift_op = instr[11:0];
            ex_d.imm      = i_bit;
            ex_d.imm24    = instr[23:0];
            ex_d.dest     = instr[15:12];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (wb_en && ({1'b0, wb_dest} < NREG)) begin
            rf_q[wb_dest] <= wb_value;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_exe_cmd  = ex_q.cmd;
    assign ex_mem_r    = ex_q.mem_r;
    assign ex_mem_w    = ex_q.mem_w;
    assign ex_wb_en    = ex_q.wb_en;
    assign ex_branch   = ex_q.branch;
    assign ex_s        = ex_q.s;
    assign ex_pc       = ex_q.pc;
    assign ex_val_rn   = ex_q.val_rn;
    assign ex_val_rm   = ex_q.val_rm;
    assign ex_shift_op = ex_q.shift_op;
    assign ex_imm      = ex_q.imm;
    assign ex_imm24    = ex_q.imm24;
    assign ex_dest     = ex_q.dest;

endmodule

// File: tb/tb_id_decode_pipe.sv
// tb_id_decode_pipe: table vectors, directed corner sequences and random
// stimulus against a behavioural model of id_decode_pipe.
module tb_id_decode_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, hazard, flush, freeze, wb_en;
    logic [31:0] instr, pc, wb_value;
    logic [3:0]  status, wb_dest;
    logic [3:0]  src1, src2;
    logic        two_src;
    logic        ex_valid, ex_mem_r, ex_mem_w, ex_wb_en, ex_branch, ex_s;
    logic [3:0]  ex_exe_cmd, ex_dest;
    logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
    logic [11:0] ex_shift_op;
    logic        ex_imm;
    logic [23:0] ex_imm24;

    id_decode_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc(pc),
        .status(status), .hazard(hazard), .flush(flush), .freeze(freeze),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .src1(src1), .src2(src2), .two_src(two_src),
        .ex_valid(ex_valid), .ex_exe_cmd(ex_exe_cmd), .ex_mem_r(ex_mem_r),
        .ex_mem_w(ex_mem_w), .ex_wb_en(ex_wb_en), .ex_branch(ex_branch),
        .ex_s(ex_s), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn),
        .ex_val_rm(ex_val_rm), .ex_shift_op(ex_shift_op), .ex_imm(ex_imm),
        .ex_imm24(ex_imm24), .ex_dest(ex_dest)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(
        input logic [3:0] c, input logic [1:0] m, input logic i,
        input logic [3:0] op, input logic s, input logic [3:0] rn,
        input logic [3:0] rd, input logic [11:0] lo);
        return {c, m, i, op, s, rn, rd, lo};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        valid;
        logic [3:0]  cmd;
        logic        mr, mw, wb, br, s;
        logic [31:0] pc, rn, rm;
        logic [11:0] sh;
        logic        imm;
        logic [23:0] i24;
        logic [3:0]  dest;
    } mex_t;

    logic [31:0] m_rf [16];
    mex_t        m_ex;
    bit          m_known;
    logic [4:0]  optab [16];

    // Conditions come in complementary pairs: even code tests, odd inverts.
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        {n, z, cf, v} = f;
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b0;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [3:0] m_src2(input logic [31:0] w);
        return (w[27:26] == 2'b01 && !w[20]) ? w[15:12] : w[3:0];
    endfunction

    function automatic bit m_two(input logic [31:0] w);
        return (w[27:26] == 2'b00 && !w[25]) ||
               (w[27:26] == 2'b01 && !w[20]);
    endfunction

    task automatic m_bubble();
        m_ex.valid = 1'b0; m_ex.cmd = 4'h0; m_ex.mr = 1'b0; m_ex.mw = 1'b0;
        m_ex.wb = 1'b0; m_ex.br = 1'b0; m_ex.s = 1'b0;
        m_known = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0]  a_i, b_i, cmd;
        logic [31:0] a, b;
        bit          legal, wbf, mr, mw, br, sf;
        a_i = instr[19:16];
        b_i = m_src2(instr);
        a = m_rf[a_i];
        b = m_rf[b_i];
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_dest == a_i) a = wb_value;
        if (wb_en && wb_dest == b_i) b = wb_value;
`endif
        if (rst) begin
            m_bubble();
            m_ex.pc = 0; m_ex.rn = 0; m_ex.rm = 0; m_ex.sh = 0;
            m_ex.imm = 0; m_ex.i24 = 0; m_ex.dest = 0;
            m_known = 1'b1;
            for (int k = 0; k < 16; k++) m_rf[k] = 32'h0;
            return;
        end
        legal = 0; wbf = 0; mr = 0; mw = 0; br = 0; sf = 0; cmd = 4'h0;
        case (instr[27:26])
            2'd0: begin
                legal = optab[instr[24:21]][4];
                cmd   = optab[instr[24:21]][3:0];
                wbf   = !(instr[24:21] == 4'hA || instr[24:21] == 4'h8);
                sf    = instr[20];
            end
            2'd1: begin
                legal = 1; cmd = 4'h2;
                mr = instr[20]; mw = !instr[20]; wbf = instr[20];
            end
            2'd2: begin legal = 1; br = 1; end
            default: legal = 0;
        endcase
        if (flush) m_bubble();
        else if (!freeze) begin
            if (in_valid && !hazard && legal &&
                cond_pass(instr[31:28], status)) begin
                m_ex.valid = 1; m_ex.cmd = cmd; m_ex.mr = mr; m_ex.mw = mw;
                m_ex.wb = wbf; m_ex.br = br; m_ex.s = sf;
                m_ex.pc = pc; m_ex.rn = a; m_ex.rm = b;
                m_ex.sh = instr[11:0]; m_ex.imm = instr[25];
                m_ex.i24 = instr[23:0]; m_ex.dest = instr[15:12];
                m_known = 1'b1;
            end else m_bubble();
        end
        if (wb_en) m_rf[wb_dest] = wb_value;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb(input string p);
        chk({p, ".src1"}, src1, instr[19:16]);
        chk({p, ".src2"}, src2, m_src2(instr));
        chk({p, ".two_src"}, two_src, m_two(instr));
    endtask

    task automatic check_ex(input string p);
        chk({p, ".valid"}, ex_valid, m_ex.valid);
        chk({p, ".cmd"}, ex_exe_cmd, m_ex.cmd);
        chk({p, ".mem_r"}, ex_mem_r, m_ex.mr);
        chk({p, ".mem_w"}, ex_mem_w, m_ex.mw);
        chk({p, ".wb_en"}, ex_wb_en, m_ex.wb);
        chk({p, ".branch"}, ex_branch, m_ex.br);
        chk({p, ".s"}, ex_s, m_ex.s);
        if (m_known) begin
            chk({p, ".pc"}, ex_pc, m_ex.pc);
            chk({p, ".rn"}, ex_val_rn, m_ex.rn);
            chk({p, ".rm"}, ex_val_rm, m_ex.rm);
            chk({p, ".shift"}, ex_shift_op, m_ex.sh);
            chk({p, ".imm"}, ex_imm, m_ex.imm);
            chk({p, ".imm24"}, ex_imm24, m_ex.i24);
            chk({p, ".dest"}, ex_dest, m_ex.dest);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [31:0] ins;
        logic [3:0]  st, s1, s2;
        logic        two, v;
        logic [3:0]  cmd;
        logic        mr, mw, wb, br, s;
        logic [31:0] rn, rm;
    } vec_t;

    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;
    localparam int NTV = 16;
    vec_t tv [NTV];

    task automatic idle();
        rst = 0; in_valid = 0; hazard = 0; flush = 0; freeze = 0;
        wb_en = 0; wb_dest = 0; wb_value = 0; status = 0;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) optab[k] = 5'h00;
        optab[13] = 5'h11; optab[15] = 5'h19; optab[4]  = 5'h12;
        optab[5]  = 5'h13; optab[2]  = 5'h14; optab[6]  = 5'h15;
        optab[0]  = 5'h16; optab[12] = 5'h17; optab[1]  = 5'h18;
        optab[10] = 5'h14; optab[8]  = 5'h16;

        tv[0]  = '{enc(4'hE,2'd0,N,4'h4,N,4'd3,4'd1,12'h003), 4'h0, 4'd3, 4'd3,
                   Y, Y, 4'h2, N, N, Y, N, N, 32'h103, 32'h103};
        tv[1]  = '{enc(4'h0,2'd2,N,4'h0,N,4'd0,4'd0,12'h000), 4'h0, 4'd0, 4'd0,
                   N, N, 4'h0, N, N, N, N, N, 32'h0, 32'h0};
        tv[2]  = '{enc(4'h0,2'd2,N,4'h0,N,4'd0,4'd0,12'h000), 4'h4, 4'd0, 4'd0,
                   N, Y, 4'h0, N, N, N, Y, N, 32'h100, 32'h100};
        tv[3]  = '{enc(4'hE,2'd1,N,4'hC,N,4'd4,4'd2,12'h000), 4'h0, 4'd4, 4'd2,
                   Y, Y, 4'h2, N, Y, N, N, N, 32'h104, 32'h102};
        tv[4]  = '{enc(4'hE,2'd1,N,4'hC,Y,4'd1,4'd7,12'h004), 4'h0, 4'd1, 4'd4,
                   N, Y, 4'h2, Y, N, Y, N, N, 32'h101, 32'h104};
        tv[5]  = '{enc(4'hE,2'd0,Y,4'hA,Y,4'd1,4'd0,12'h007), 4'h0, 4'd1, 4'd7,
                   N, Y, 4'h4, N, N, N, N, Y, 32'h101, 32'h107};
        tv[6]  = '{enc(4'hE,2'd0,N,4'h8,Y,4'd2,4'd0,12'h003), 4'h0, 4'd2, 4'd3,
                   Y, Y, 4'h6, N, N, N, N, Y, 32'h102, 32'h103};
        tv[7]  = '{enc(4'hE,2'd0,N,4'hF,N,4'd0,4'd0,12'h001), 4'h0, 4'd0, 4'd1,
                   Y, Y, 4'h9, N, N, Y, N, N, 32'h100, 32'h101};
        tv[8]  = '{enc(4'hE,2'd0,N,4'h3,N,4'd1,4'd2,12'h003), 4'h0, 4'd1, 4'd3,
                   Y, N, 4'h0, N, N, N, N, N, 32'h0, 32'h0};
        tv[9]  = '{enc(4'hE,2'd3,N,4'h4,N,4'd1,4'd2,12'h003), 4'h0, 4'd1, 4'd3,
                   N, N, 4'h0, N, N, N, N, N, 32'h0, 32'h0};
        tv[10] = '{enc(4'hF,2'd0,N,4'h4,N,4'd1,4'd2,12'h003), 4'h0, 4'd1, 4'd3,
                   Y, N, 4'h0, N, N, N, N, N, 32'h0, 32'h0};
        tv[11] = '{enc(4'hC,2'd0,N,4'hC,N,4'd5,4'd6,12'h007), 4'h0, 4'd5, 4'd7,
                   Y, Y, 4'h7, N, N, Y, N, N, 32'h105, 32'h107};
        tv[12] = '{enc(4'hB,2'd0,Y,4'h1,Y,4'd8,4'd9,12'h00A), 4'h8, 4'd8, 4'hA,
                   N, Y, 4'h8, N, N, Y, N, Y, 32'h108, 32'h10A};
        tv[13] = '{enc(4'h8,2'd0,N,4'h2,N,4'd1,4'd2,12'h003), 4'h6, 4'd1, 4'd3,
                   Y, N, 4'h0, N, N, N, N, N, 32'h0, 32'h0};
        tv[14] = '{enc(4'h4,2'd0,N,4'h6,N,4'd9,4'hA,12'h00B), 4'h8, 4'd9, 4'hB,
                   Y, Y, 4'h5, N, N, Y, N, N, 32'h109, 32'h10B};
        tv[15] = '{enc(4'h9,2'd0,Y,4'h0,N,4'hC,4'hD,12'h0FE), 4'h0, 4'hC, 4'hE,
                   N, Y, 4'h6, N, N, Y, N, N, 32'h10C, 32'h10E};

        // Reset state
        idle(); instr = 0; pc = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        check_ex("reset");
        chk("reset.ex_valid", ex_valid, 1'b0);
        chk("reset.ex_pc", ex_pc, 32'h0);

        // Write R3=5 then ADD R1,R3,R3
        wb_en = 1; wb_dest = 4'd3; wb_value = 32'h5;
        tick();
        wb_en = 0; in_valid = 1; pc = 32'h10;
        instr = enc(4'hE, 2'd0, N, 4'h4, N, 4'd3, 4'd1, 12'h003);
        tick();
        chk("add.valid", ex_valid, 1'b1);
        chk("add.cmd", ex_exe_cmd, 4'h2);
        chk("add.rn", ex_val_rn, 32'h5);
        chk("add.rm", ex_val_rm, 32'h5);
        chk("add.wb_en", ex_wb_en, 1'b1);
        chk("add.dest", ex_dest, 4'd1);

        // Preset Rk = 0x100+k
        in_valid = 0;
        for (int k = 0; k < 16; k++) begin
            wb_en = 1; wb_dest = 4'(k); wb_value = 32'h100 + k;
            tick();
        end
        wb_en = 0;

        // Table vectors
        for (int i = 0; i < NTV; i++) begin
            string p;
            p = $sformatf("tv%0d", i);
            in_valid = 1; instr = tv[i].ins; status = tv[i].st;
            pc = 32'h1000 + 4 * i;
            #1;
            chk({p, ".src1"}, src1, tv[i].s1);
            chk({p, ".src2"}, src2, tv[i].s2);
            chk({p, ".two_src"}, two_src, tv[i].two);
            tick();
            chk({p, ".valid"}, ex_valid, tv[i].v);
            chk({p, ".cmd"}, ex_exe_cmd, tv[i].cmd);
            chk({p, ".mem_r"}, ex_mem_r, tv[i].mr);
            chk({p, ".mem_w"}, ex_mem_w, tv[i].mw);
            chk({p, ".wb_en"}, ex_wb_en, tv[i].wb);
            chk({p, ".branch"}, ex_branch, tv[i].br);
            chk({p, ".s"}, ex_s, tv[i].s);
            if (tv[i].v) begin
                chk({p, ".rn"}, ex_val_rn, tv[i].rn);
                chk({p, ".rm"}, ex_val_rm, tv[i].rm);
                chk({p, ".pc"}, ex_pc, 32'h1000 + 4 * i);
                chk({p, ".dest"}, ex_dest, tv[i].ins[15:12]);
            end
        end
        status = 0;

        // Freeze holds, register writes continue underneath
        instr = enc(4'hE, 2'd0, N, 4'h4, N, 4'd3, 4'd1, 12'h003);
        pc = 32'h2000;
        tick();
        for (int k = 0; k < 3; k++) begin
            freeze = 1; pc = 32'h2100 + k;
            instr = enc(4'hE, 2'd0, N, 4'hD, N, 4'd0, 4'd5, 12'h004);
            wb_en = (k == 0); wb_dest = 4'd3; wb_value = 32'h333;
            tick();
            chk("frz.valid", ex_valid, 1'b1);
            chk("frz.pc", ex_pc, 32'h2000);
            chk("frz.cmd", ex_exe_cmd, 4'h2);
            chk("frz.rn", ex_val_rn, 32'h103);
            chk("frz.dest", ex_dest, 4'd1);
        end
        wb_en = 0; freeze = 0;
        instr = enc(4'hE, 2'd0, N, 4'h4, N, 4'd3, 4'd1, 12'h003);
        tick();
        chk("frzwr.rn", ex_val_rn, 32'h333);
        freeze = 1; flush = 1;
        tick();
        chk("frzfl.valid", ex_valid, 1'b0);
        chk("frzfl.cmd", ex_exe_cmd, 4'h0);
        chk("frzfl.wb_en", ex_wb_en, 1'b0);
        freeze = 0; flush = 0;

        // Hazard bubble
        hazard = 1;
        tick();
        chk("haz.valid", ex_valid, 1'b0);
        chk("haz.wb_en", ex_wb_en, 1'b0);
        hazard = 0;

        // Same-cycle write and read of R5
        instr = enc(4'hE, 2'd0, N, 4'hD, N, 4'd0, 4'd0, 12'h005);
        wb_en = 1; wb_dest = 4'd5; wb_value = 32'hDEAD_BEEF;
        tick();
`ifdef ID_WB_BYPASS_EN
        chk("byp.rm", ex_val_rm, 32'hDEAD_BEEF);
`else
        chk("byp.rm", ex_val_rm, 32'h105);
`endif
        chk("byp.cmd", ex_exe_cmd, 4'h1);
        wb_en = 0;
        tick();
        chk("byp2.rm", ex_val_rm, 32'hDEAD_BEEF);

        // Reset discards a frozen instruction and a concurrent write
        instr = enc(4'hE, 2'd0, N, 4'h4, N, 4'd6, 4'd1, 12'h006);
        pc = 32'h4000;
        tick();
        chk("pre.rn", ex_val_rn, 32'h106);
        rst = 1; freeze = 1;
        wb_en = 1; wb_dest = 4'd6; wb_value = 32'hAAAA;
        tick();
        chk("rstfrz.valid", ex_valid, 1'b0);
        chk("rstfrz.pc", ex_pc, 32'h0);
        chk("rstfrz.rn", ex_val_rn, 32'h0);
        chk("rstfrz.cmd", ex_exe_cmd, 4'h0);
        rst = 0; freeze = 0; wb_en = 0; pc = 32'h4100;
        tick();
        chk("post.valid", ex_valid, 1'b1);
        chk("post.pc", ex_pc, 32'h4100);
        chk("post.rn", ex_val_rn, 32'h0);
        chk("post.rm", ex_val_rm, 32'h0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            rst      = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 9) != 0);
            hazard   = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            freeze   = ($urandom_range(0, 6) == 0);
            wb_en    = $urandom_range(0, 1) == 1;
            wb_dest  = 4'($urandom_range(0, 15));
            wb_value = $urandom;
            status   = 4'($urandom_range(0, 15));
            instr    = $urandom;
            if ($urandom_range(0, 1) == 1) instr[31:28] = 4'hE;
            pc = $urandom;
            #1;
            check_comb("rnd");
            tick();
            check_ex("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_decode_pipe.md
ID_DECODE_PIPE -- requirements
Module: id_decode_pipe

Interface
REQ-001 Parameter DATA_W, 32, width of register values, PC and write-back data.
REQ-002 Parameter NUM_REGS, 16, implemented registers (2..16); indices >= NUM_REGS read 0 and ignore writes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  instr/pc carry a real instruction.
REQ-006 instr  input  32  ARM-style word: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shifter[11:0], imm24[23:0].
REQ-007 pc  input  DATA_W  PC accompanying instr.
REQ-008 status  input  4  NZCV flags.
REQ-009 hazard, flush, freeze  input  1 each  bubble request, squash, hold.
REQ-010 wb_en, wb_dest[3:0], wb_value[DATA_W-1:0]  input  write-back port.
REQ-011 src1, src2  output  4 each  combinational read indices; two_src  output  1  combinational, instr needs src2.
REQ-012 ex_valid, ex_exe_cmd[3:0], ex_mem_r, ex_mem_w, ex_wb_en, ex_branch, ex_s  output  registered controls.
REQ-013 ex_pc, ex_val_rn, ex_val_rm  output  DATA_W  registered; ex_shift_op[11:0], ex_imm, ex_imm24[23:0], ex_dest[3:0]  output  registered fields.

Function
REQ-014 src1 SHALL equal Rn; src2 SHALL equal Rd for stores (mode 01, S=0), else Rm=instr[3:0].
REQ-015 two_src SHALL be 1 for mode 00 with I=0 or for stores, else 0.
REQ-016 Decode, mode 00, opcode->EXE_CMD: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; other opcodes SHALL decode as bubble.
REQ-017 wb_en SHALL be 1 for all mode-00 ops except CMP/TST, and for LDR; ex_s SHALL equal S for mode 00, 0 otherwise.
REQ-018 Mode 01: S=1 LDR (mem_r=1, cmd 0010), S=0 STR (mem_w=1, cmd 0010); mode 10 SHALL set branch=1, cmd 0000; mode 11 SHALL decode as bubble.
REQ-019 Condition codes 0000-1101 SHALL follow ARM EQ..LE semantics on NZCV, 1110 always passes, 1111 always fails.
REQ-020 Register file: NUM_REGS x DATA_W, two async read ports, one write port written on clk edge when wb_en=1.
REQ-021 Per-edge priority: rst > flush > freeze > (hazard | !in_valid | condition fail | illegal decode) > normal load.
REQ-022 Normal load: all ex_* outputs capture decoded values next edge, ex_valid=1; latency exactly one cycle.
REQ-023 Bubble (flush, hazard, invalid, cond fail, illegal): ex_valid, ex_mem_r, ex_mem_w, ex_wb_en, ex_branch, ex_s, ex_exe_cmd SHALL load 0; data fields may load any value.
REQ-024 freeze without flush SHALL hold every ex_* output unchanged; register-file writes SHALL still occur.
REQ-025 Write and read of same index in one cycle: value returned governed by REQ-031.

Reset
REQ-026 On rst edge all ex_* outputs SHALL become 0, including ex_valid.
REQ-027 On rst edge all register-file entries SHALL become 0; a simultaneous wb_en write SHALL be discarded.
REQ-028 rst asserted mid-operation SHALL discard a held (frozen) instruction; first capture occurs on the first edge after rst deasserts.

Configuration
REQ-029 Macro ID_WB_BYPASS_EN SHALL select write-through read behaviour.
REQ-030 Defined: when wb_en=1 and wb_dest equals src1/src2 (index < NUM_REGS), that read SHALL return wb_value in the same cycle.
REQ-031 Undefined: reads SHALL return the pre-write stored value; the new value is visible the cycle after.

Verification
REQ-032 rst, then write R3=0x0000_0005, then ADD R1,R3,R3 (cond 1110, I=0) -> next cycle ex_valid=1, cmd 0010, ex_val_rn=ex_val_rm=5, ex_wb_en=1, ex_dest=1.
REQ-033 status Z=0, BEQ (cond 0000, mode 10) -> ex_valid=0, ex_branch=0; with Z=1 -> ex_branch=1.
REQ-034 STR R2,[R4] -> src2=2, two_src=1, ex_mem_w=1, ex_wb_en=0; CMP R1,#7 (I=1) -> two_src=0, ex_wb_en=0, ex_s=1.
REQ-035 freeze=1 for 3 cycles with new instrs on input -> ex_* constant; freeze with flush=1 -> ex_valid=0 next edge.
REQ-036 wb_en=1 wb_dest=5 wb_value=0xDEAD_BEEF while decoding MOV R0,R5 -> ex_val_rm=0xDEAD_BEEF with ID_WB_BYPASS_EN, old R5 value without.
